// File: rtl/dmux_rr_sequencer_if.sv
// dmux_rr_sequencer_if: control, serial stream and demux drive signals of the round-robin sequencer
interface dmux_rr_sequencer_if #(parameter int DWELL_W = 4);
  logic start;
  logic stop;
  logic [DWELL_W-1:0] dwell;
  logic [3:0] ch_mask;
  logic din_valid;
  logic din;
  logic din_ready;
  logic dmux_in;
  logic dmux_sel0;
  logic dmux_sel1;
  logic busy;
  logic wrap;
  logic cfg_err;
  modport master (
    output start, stop, dwell, ch_mask, din_valid, din,
    input din_ready, dmux_in, dmux_sel0, dmux_sel1, busy, wrap, cfg_err
  );
  modport slave (
    input start, stop, dwell, ch_mask, din_valid, din,
    output din_ready, dmux_in, dmux_sel0, dmux_sel1, busy, wrap, cfg_err
  );
endinterface

// File: rtl/dmux_rr_sequencer.sv
// dmux_rr_sequencer: steers a serial stream round-robin across enabled 1-to-4 demux outputs
module dmux_rr_sequencer #(parameter int DWELL_W = 4) (
  input logic clk,
  input logic rst,
  dmux_rr_sequencer_if.slave bus
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [1:0] ch, nxt, first;
  logic [3:0] mask_l;
  logic [DWELL_W-1:0] cnt, dwell_l, last;
  logic acc, adv;
  assign bus.din_ready = (state == RUN) && !bus.stop && !rst;
  assign acc = bus.din_valid && bus.din_ready;
  assign last = (dwell_l == '0) ? '0 : dwell_l - DWELL_W'(1);
  assign adv = acc && (cnt == last);
  assign first = bus.ch_mask[0] ? 2'd0 : bus.ch_mask[1] ? 2'd1 : bus.ch_mask[2] ? 2'd2 : 2'd3;
  // descending scan so the nearest enabled channel above ch wins; ch itself if it is the only one
  always_comb begin
    nxt = ch;
    for (int i = 3; i >= 1; i--)
      if (mask_l[2'(ch + 2'(i))]) nxt = 2'(ch + 2'(i));
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      cnt <= '0;
      mask_l <= '0;
      dwell_l <= '0;
      bus.dmux_in <= 1'b0;
      bus.dmux_sel0 <= 1'b0;
      bus.dmux_sel1 <= 1'b0;
      bus.busy <= 1'b0;
      bus.wrap <= 1'b0;
      bus.cfg_err <= 1'b0;
    end else begin
      bus.dmux_in <= acc && bus.din;
      bus.wrap <= adv && (nxt <= ch);
      bus.cfg_err <= (state == IDLE) && bus.start && (bus.ch_mask == '0);
      if (acc) {bus.dmux_sel0, bus.dmux_sel1} <= ch;
      if (state == IDLE) begin
        if (bus.start && |bus.ch_mask) begin
          state <= RUN;
          bus.busy <= 1'b1;
          ch <= first;
          cnt <= '0;
          mask_l <= bus.ch_mask;
          dwell_l <= bus.dwell;
        end
      end else if (bus.stop) begin
        state <= IDLE;
        bus.busy <= 1'b0;
      end else if (acc) begin
        cnt <= adv ? '0 : cnt + DWELL_W'(1);
        if (adv) ch <= nxt;
      end
    end
  end
endmodule

// File: tb/tb_dmux_rr_sequencer.sv
// tb_dmux_rr_sequencer: scoreboard bench for the round-robin demux sequencer
module tb_dmux_rr_sequencer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  bit m_run;
  logic [1:0] m_ch, last_sel;
  int m_cnt, m_dwell;
  logic [3:0] m_mask;
  logic [3:0] q[$];
  dmux_rr_sequencer_if #(.DWELL_W(4)) bus();
  dmux_rr_sequencer #(.DWELL_W(4)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [1:0] next_ch(input logic [1:0] c, input logic [3:0] m);
    for (int i = 1; i <= 4; i++)
      if (m[(int'(c) + i) % 4]) return 2'((int'(c) + i) % 4);
    return c;
  endfunction
  function automatic logic [1:0] low_ch(input logic [3:0] m);
    for (int i = 0; i < 4; i++)
      if (m[i]) return 2'(i);
    return 2'd0;
  endfunction
  task automatic do_rst(input int n);
    for (int k = 0; k < n; k++) begin
      rst = 1'b1;
      bus.din_valid = 1'b1;
      bus.din = 1'b1;
      bus.start = 1'b1;
      bus.stop = 1'b0;
      #1 check("rst_ready", bus.din_ready, 0);
      @(posedge clk);
      @(negedge clk);
      check("rst_out", {bus.dmux_in, bus.dmux_sel0, bus.dmux_sel1, bus.busy, bus.wrap, bus.cfg_err}, 0);
    end
    rst = 1'b0;
    bus.din_valid = 1'b0;
    bus.din = 1'b0;
    bus.start = 1'b0;
    m_run = 0;
    m_cnt = 0;
    last_sel = 2'd0;
    q.delete();
  endtask
  task automatic cyc(input logic v, input logic d, input logic s, input logic p);
    logic exp_rdy, exp_cfg, adv, w;
    logic [1:0] n;
    logic [3:0] e;
    int eff;
    bus.din_valid = v;
    bus.din = d;
    bus.start = s;
    bus.stop = p;
    exp_rdy = m_run && !p;
    exp_cfg = 1'b0;
    #1 check("din_ready", bus.din_ready, exp_rdy);
    if (!m_run) begin
      if (s && bus.ch_mask == 4'd0) exp_cfg = 1'b1;
      else if (s) begin
        m_run = 1;
        m_ch = low_ch(bus.ch_mask);
        m_cnt = 0;
        m_mask = bus.ch_mask;
        m_dwell = int'(bus.dwell);
      end
    end else if (p) m_run = 0;
    else if (v) begin
      eff = (m_dwell == 0) ? 1 : m_dwell;
      adv = (m_cnt == eff - 1);
      n = adv ? next_ch(m_ch, m_mask) : m_ch;
      w = adv && (n <= m_ch);
      q.push_back({d, m_ch, w});
      if (adv) begin
        m_cnt = 0;
        m_ch = n;
      end else m_cnt++;
    end
    @(posedge clk);
    @(negedge clk);
    if (q.size() > 0) begin
      e = q.pop_front();
      check("dmux_in", bus.dmux_in, e[3]);
      check("sel", {bus.dmux_sel0, bus.dmux_sel1}, e[2:1]);
      check("wrap", bus.wrap, e[0]);
      last_sel = e[2:1];
    end else begin
      check("idle_in", bus.dmux_in, 0);
      check("hold_sel", {bus.dmux_sel0, bus.dmux_sel1}, last_sel);
      check("idle_wrap", bus.wrap, 0);
    end
    check("busy", bus.busy, m_run);
    check("cfg_err", bus.cfg_err, exp_cfg);
  endtask
  task automatic run_t2();
    bus.ch_mask = 4'b1111;
    bus.dwell = 4'd1;
    cyc(0, 0, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 0);
  endtask
  initial begin
    bus.ch_mask = 4'd0;
    bus.dwell = 4'd0;
    bus.stop = 1'b0;
    do_rst(2);
    run_t2();
    cyc(0, 0, 0, 1);
    bus.ch_mask = 4'b1010;
    bus.dwell = 4'd3;
    cyc(0, 0, 1, 0);
    bus.ch_mask = 4'b0001;
    bus.dwell = 4'd1;
    for (int k = 0; k < 6; k++) begin
      cyc(1, 1, k == 2, 0);
      if (k % 2 == 1) cyc(0, 1, 0, 0);
    end
    cyc(0, 0, 0, 1);
    bus.ch_mask = 4'b0000;
    cyc(0, 0, 1, 0);
    cyc(0, 0, 0, 0);
    bus.ch_mask = 4'b0100;
    bus.dwell = 4'd0;
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 3; k++) cyc(1, k[0], 0, 0);
    cyc(0, 0, 0, 1);
    bus.ch_mask = 4'b0110;
    bus.dwell = 4'd3;
    cyc(0, 0, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 1);
    cyc(1, 1, 0, 0);
    cyc(0, 0, 1, 0);
    for (int k = 0; k < 4; k++) cyc(1, 1, 0, 0);
    cyc(0, 0, 0, 1);
    bus.ch_mask = 4'b1111;
    bus.dwell = 4'd4;
    cyc(0, 0, 1, 0);
    cyc(1, 1, 0, 0);
    cyc(1, 0, 0, 0);
    do_rst(1);
    run_t2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
